// File: rtl/redmule_pkg.sv
// rtl/redmule_pkg.sv - shared types and constants for the RedMulE Z collector
package redmule_pkg;

  // Collector control states
  typedef enum logic [1:0] {
    IDLE,
    ACC,
    EMIT,
    DONE
  } zcoll_state_e;

  localparam int ZCOLL_DW   = 288;
  localparam int ZCOLL_IN_W = 96;
  localparam int ZCOLL_PACK = ZCOLL_DW / ZCOLL_IN_W;

endpackage

// File: rtl/redmule_z_packer.sv
// rtl/redmule_z_packer.sv - slot-indexed beat register packing engine slices with byte strobes
module redmule_z_packer
  import redmule_pkg::*;
#(
  parameter int DW   = ZCOLL_DW,
  parameter int IN_W = ZCOLL_IN_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear,
  input  logic              wr_en,
  input  logic              wr_last,
  input  logic [IN_W-1:0]   wr_data,
  output logic [DW-1:0]     data,
  output logic [DW/8-1:0]   strb,
  output logic              close
);

  localparam int PACK  = DW / IN_W;
  localparam int SW    = IN_W / 8;
  localparam int IDX_W = (PACK > 1) ? $clog2(PACK) : 1;

  logic [IDX_W-1:0] idx_q;
  logic [DW-1:0]    data_q;
  logic [DW/8-1:0]  strb_q;

  // The write that fills the last slot, or one flagged as row end, closes the beat
  assign close = wr_en && ((idx_q == IDX_W'(PACK - 1)) || wr_last);
  assign data  = data_q;
  assign strb  = strb_q;

  // Slot writes; clear wipes the whole beat so unfilled slots read as zero with no strobe
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      idx_q  <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else if (clear) begin
      idx_q  <= '0;
      data_q <= '0;
      strb_q <= '0;
    end else if (wr_en) begin
      data_q[idx_q*IN_W +: IN_W] <= wr_data;
      strb_q[idx_q*SW +: SW]     <= '1;
      idx_q                      <= close ? '0 : idx_q + IDX_W'(1);
    end
  end

endmodule

// File: rtl/redmule_z_collector.sv
// rtl/redmule_z_collector.sv - packs engine slices into Z beats and tracks tile completion; REDMULE_ZCOLL_STALL_CNT_EN adds a stall counter
module redmule_z_collector
  import redmule_pkg::*;
#(
  parameter int DW    = ZCOLL_DW,
  parameter int IN_W  = ZCOLL_IN_W,
  parameter int CNT_W = 16
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              clear_i,
  input  logic              start_i,
  input  logic [CNT_W-1:0]  tot_beats_i,
  input  logic [IN_W-1:0]   in_data_i,
  input  logic              in_valid_i,
  input  logic              in_last_i,
  output logic              in_ready_o,
  output logic [DW-1:0]     z_data_o,
  output logic [DW/8-1:0]   z_strb_o,
  output logic              z_valid_o,
  input  logic              z_ready_i,
  output logic              busy_o,
  output logic              done_o,
  output logic [CNT_W-1:0]  beat_cnt_o,
  output logic [31:0]       stall_cnt_o
);

  if (DW % IN_W != 0) begin : g_bad_dw
    $error("DW must be a multiple of IN_W");
  end
  if (IN_W % 8 != 0) begin : g_bad_in_w
    $error("IN_W must be a whole number of bytes");
  end

  zcoll_state_e     state_q;
  logic [CNT_W-1:0] beat_cnt_q;
  logic [CNT_W-1:0] tot_q;
  logic [CNT_W-1:0] beat_cnt_nxt;
  logic             done_q;
  logic             accept;
  logic             handshake;
  logic             close;

  assign in_ready_o   = (state_q == ACC);
  assign z_valid_o    = (state_q == EMIT);
  assign busy_o       = (state_q != IDLE);
  assign done_o       = done_q;
  assign beat_cnt_o   = beat_cnt_q;
  assign accept       = in_ready_o && in_valid_i;
  assign handshake    = z_valid_o && z_ready_i;
  assign beat_cnt_nxt = beat_cnt_q + CNT_W'(1);

  redmule_z_packer #(
    .DW   (DW),
    .IN_W (IN_W)
  ) i_packer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .clear   (clear_i || handshake),
    .wr_en   (accept),
    .wr_last (in_last_i),
    .wr_data (in_data_i),
    .data    (z_data_o),
    .strb    (z_strb_o),
    .close   (close)
  );

  // Tile sequencing: accumulate a beat, hold it until the sink takes it, stop after tot beats
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      tot_q      <= '0;
      done_q     <= 1'b0;
    end else if (clear_i) begin
      state_q    <= IDLE;
      beat_cnt_q <= '0;
      tot_q      <= '0;
      done_q     <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_i) begin
            if (tot_beats_i == '0) begin
              done_q <= 1'b1;
            end else begin
              tot_q      <= tot_beats_i;
              beat_cnt_q <= '0;
              state_q    <= ACC;
            end
          end
        end
        ACC: begin
          if (close) state_q <= EMIT;
        end
        EMIT: begin
          if (z_ready_i) begin
            beat_cnt_q <= beat_cnt_nxt;
            if (beat_cnt_nxt == tot_q) begin
              state_q <= DONE;
              done_q  <= 1'b1;
            end else begin
              state_q <= ACC;
            end
          end
        end
        DONE: state_q <= IDLE;
        default: state_q <= IDLE;
      endcase
    end
  end

`ifdef REDMULE_ZCOLL_STALL_CNT_EN
  logic [31:0] stall_q;
  logic        start_acc;

  assign start_acc   = (state_q == IDLE) && start_i;
  assign stall_cnt_o = stall_q;

  // Saturating count of cycles the sink holds off a valid beat
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      stall_q <= '0;
    end else if (clear_i || start_acc) begin
      stall_q <= '0;
    end else if (z_valid_o && !z_ready_i && (stall_q != '1)) begin
      stall_q <= stall_q + 32'd1;
    end
  end
`else
  assign stall_cnt_o = '0;
`endif

endmodule

// File: tb/tb_redmule_z_collector.sv
// tb/tb_redmule_z_collector.sv - self-checking bench for redmule_z_collector
module tb_redmule_z_collector;

  localparam int DW    = 288;
  localparam int IN_W  = 96;
  localparam int CNT_W = 16;
  localparam int SB    = DW / 8;
  localparam int PACK  = DW / IN_W;

  logic             clk = 1'b0;
  logic             rst;
  logic             clear_i;
  logic             start_i;
  logic [CNT_W-1:0] tot_beats_i;
  logic [IN_W-1:0]  in_data_i;
  logic             in_valid_i;
  logic             in_last_i;
  logic             in_ready_o;
  logic [DW-1:0]    z_data_o;
  logic [SB-1:0]    z_strb_o;
  logic             z_valid_o;
  logic             z_ready_i;
  logic             busy_o;
  logic             done_o;
  logic [CNT_W-1:0] beat_cnt_o;
  logic [31:0]      stall_cnt_o;

  int checks = 0;
  int errors = 0;

  logic [IN_W-1:0] sd_q[$];
  logic            sl_q[$];
  logic [DW-1:0]   ed_q[$];
  logic [SB-1:0]   es_q[$];

  typedef struct {
    int                        tot;
    int                        n;
    logic [5:0][IN_W-1:0]      d;
    logic [5:0]                last;
    logic [1:0][DW-1:0]        ed;
    logic [1:0][SB-1:0]        es;
  } vec_t;

  vec_t vecs[3];

  redmule_z_collector #(.DW(DW), .IN_W(IN_W), .CNT_W(CNT_W)) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .clear_i     (clear_i),
    .start_i     (start_i),
    .tot_beats_i (tot_beats_i),
    .in_data_i   (in_data_i),
    .in_valid_i  (in_valid_i),
    .in_last_i   (in_last_i),
    .in_ready_o  (in_ready_o),
    .z_data_o    (z_data_o),
    .z_strb_o    (z_strb_o),
    .z_valid_o   (z_valid_o),
    .z_ready_i   (z_ready_i),
    .busy_o      (busy_o),
    .done_o      (done_o),
    .beat_cnt_o  (beat_cnt_o),
    .stall_cnt_o (stall_cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk_w(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk_i({tag, "_in_ready"}, int'(in_ready_o), 0);
    chk_i({tag, "_z_valid"}, int'(z_valid_o), 0);
    chk_i({tag, "_busy"}, int'(busy_o), 0);
    chk_i({tag, "_done"}, int'(done_o), 0);
    chk_w({tag, "_z_data"}, z_data_o, '0);
    chk_w({tag, "_z_strb"}, DW'(z_strb_o), '0);
    chk_i({tag, "_beat_cnt"}, int'(beat_cnt_o), 0);
    chk_i({tag, "_stall_cnt"}, int'(stall_cnt_o), 0);
  endtask

  // Reference model: lay slices into beats slot by slot, closing on full or row end
  task automatic gen_random_tile(input int tot);
    logic [DW-1:0]   cur;
    logic [SB-1:0]   curs;
    logic [IN_W-1:0] d;
    logic            last;
    int              slot;
    int              beats;
    sd_q.delete(); sl_q.delete(); ed_q.delete(); es_q.delete();
    cur = '0; curs = '0; slot = 0; beats = 0;
    while (beats < tot) begin
      d    = {$urandom, $urandom, $urandom};
      last = ($urandom_range(0, 3) == 0);
      sd_q.push_back(d);
      sl_q.push_back(last);
      cur  = cur | ({{(DW-IN_W){1'b0}}, d} << (slot * IN_W));
      curs = curs | ({{(SB-IN_W/8){1'b0}}, {(IN_W/8){1'b1}}} << (slot * (IN_W/8)));
      slot++;
      if (last || slot == PACK) begin
        ed_q.push_back(cur);
        es_q.push_back(curs);
        cur = '0; curs = '0; slot = 0;
        beats++;
      end
    end
  endtask

  // mode 0: sink always ready, 1: random backpressure, 2: first 5 valid cycles stalled
  task automatic run_tile(input int tot, input int mode);
    int            si;
    int            stalls;
    int            dones;
    int            bp;
    logic          prev_stall;
    logic [DW-1:0] prev_d;
    logic [SB-1:0] prev_s;
    si = 0; stalls = 0; dones = 0; bp = 0; prev_stall = 1'b0;
    prev_d = '0; prev_s = '0;
    start_i     = 1'b1;
    tot_beats_i = CNT_W'(tot);
    @(posedge clk); #1;
    start_i = 1'b0;
    chk_i("busy_after_start", int'(busy_o), 1);
    for (int cyc = 0; cyc < 2000 && dones == 0; cyc++) begin
      in_valid_i = (si < sd_q.size());
      in_data_i  = in_valid_i ? sd_q[si] : '0;
      in_last_i  = in_valid_i ? sl_q[si] : 1'b0;
      case (mode)
        0:       z_ready_i = 1'b1;
        1:       z_ready_i = ($urandom_range(0, 2) != 0);
        default: z_ready_i = (bp >= 5);
      endcase
      if (prev_stall) begin
        chk_i("hold_valid", int'(z_valid_o), 1);
        chk_w("hold_data", z_data_o, prev_d);
        chk_w("hold_strb", DW'(z_strb_o), DW'(prev_s));
      end
      if (z_valid_o) begin
        chk_i("in_ready_low_in_emit", int'(in_ready_o), 0);
        if (!z_ready_i) begin
          stalls++;
          bp++;
        end
      end
      if (z_valid_o && z_ready_i) begin
        if (ed_q.size() == 0) begin
          chk_i("unexpected_beat", 1, 0);
        end else begin
          chk_w("beat_data", z_data_o, ed_q[0]);
          chk_w("beat_strb", DW'(z_strb_o), DW'(es_q[0]));
          void'(ed_q.pop_front());
          void'(es_q.pop_front());
        end
      end
      if (in_ready_o && in_valid_i) si++;
      prev_stall = z_valid_o && !z_ready_i;
      prev_d     = z_data_o;
      prev_s     = z_strb_o;
      @(posedge clk); #1;
      if (done_o) dones++;
    end
    in_valid_i = 1'b0;
    in_last_i  = 1'b0;
    z_ready_i  = 1'b1;
    chk_i("done_seen", dones, 1);
    chk_i("beats_left", ed_q.size(), 0);
    chk_i("slices_used", si, sd_q.size());
    chk_i("beat_cnt_final", int'(beat_cnt_o), tot);
`ifdef REDMULE_ZCOLL_STALL_CNT_EN
    chk_i("stall_cnt", int'(stall_cnt_o), stalls);
`else
    chk_i("stall_cnt_tied", int'(stall_cnt_o), 0);
`endif
    @(posedge clk); #1;
    chk_i("done_single_pulse", int'(done_o), 0);
    chk_i("busy_after_done", int'(busy_o), 0);
  endtask

  initial begin
    int acc;
    int dn;
    rst = 1'b1; clear_i = 1'b0; start_i = 1'b0; tot_beats_i = '0;
    in_data_i = '0; in_valid_i = 1'b0; in_last_i = 1'b0; z_ready_i = 1'b0;

    vecs[0].tot = 2; vecs[0].n = 6;
    vecs[0].d    = {96'h6, 96'h5, 96'h4, 96'h3, 96'h2, 96'h1};
    vecs[0].last = 6'b000000;
    vecs[0].ed   = {{96'h6, 96'h5, 96'h4}, {96'h3, 96'h2, 96'h1}};
    vecs[0].es   = {36'hF_FFFF_FFFF, 36'hF_FFFF_FFFF};
    vecs[1].tot = 1; vecs[1].n = 1;
    vecs[1].d    = {480'h0, 96'hA};
    vecs[1].last = 6'b000001;
    vecs[1].ed   = {288'h0, 288'hA};
    vecs[1].es   = {36'h0, 36'h0_0000_0FFF};
    vecs[2].tot = 2; vecs[2].n = 3;
    vecs[2].d    = {96'h0, 96'h0, 96'h0, 96'h22, 96'h21, 96'h11};
    vecs[2].last = 6'b000101;
    vecs[2].ed   = {{96'h0, 96'h22, 96'h21}, 288'h11};
    vecs[2].es   = {36'h0_00FF_FFFF, 36'h0_0000_0FFF};

    #1;
    chk_idle_outputs("reset");
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    z_ready_i = 1'b1;
    @(posedge clk); #1;
    chk_idle_outputs("post_reset");

    for (int i = 0; i < 3; i++) begin
      sd_q.delete(); sl_q.delete(); ed_q.delete(); es_q.delete();
      for (int j = 0; j < vecs[i].n; j++) begin
        sd_q.push_back(vecs[i].d[j]);
        sl_q.push_back(vecs[i].last[j]);
      end
      for (int j = 0; j < vecs[i].tot; j++) begin
        ed_q.push_back(vecs[i].ed[j]);
        es_q.push_back(vecs[i].es[j]);
      end
      run_tile(vecs[i].tot, 0);
    end

    // Backpressure: three slices then the sink stalls five cycles
    sd_q.delete(); sl_q.delete(); ed_q.delete(); es_q.delete();
    sd_q.push_back(96'hC1); sd_q.push_back(96'hC2); sd_q.push_back(96'hC3);
    sl_q.push_back(1'b0); sl_q.push_back(1'b0); sl_q.push_back(1'b0);
    ed_q.push_back({96'hC3, 96'hC2, 96'hC1});
    es_q.push_back('1);
    run_tile(1, 2);
`ifdef REDMULE_ZCOLL_STALL_CNT_EN
    chk_i("bp_stall_is_5", int'(stall_cnt_o), 5);
`endif

    // Zero-length tile
    start_i = 1'b1; tot_beats_i = '0;
    @(posedge clk); #1;
    start_i = 1'b0;
    chk_i("zero_done", int'(done_o), 1);
    chk_i("zero_busy", int'(busy_o), 0);
    chk_i("zero_valid", int'(z_valid_o), 0);
    @(posedge clk); #1;
    chk_i("zero_done_once", int'(done_o), 0);
    chk_i("zero_valid_after", int'(z_valid_o), 0);

    // Mid-tile clear after four accepted slices
    start_i = 1'b1; tot_beats_i = CNT_W'(3);
    @(posedge clk); #1;
    start_i = 1'b0;
    acc = 0;
    for (int cyc = 0; cyc < 200 && acc < 4; cyc++) begin
      in_valid_i = 1'b1;
      in_data_i  = IN_W'(acc + 1);
      in_last_i  = 1'b0;
      z_ready_i  = 1'b1;
      if (in_ready_o) acc++;
      @(posedge clk); #1;
    end
    chk_i("abort_slices_taken", acc, 4);
    in_valid_i = 1'b0;
    clear_i = 1'b1;
    @(posedge clk); #1;
    clear_i = 1'b0;
    chk_idle_outputs("after_clear");
    dn = 0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      if (done_o) dn++;
    end
    chk_i("clear_no_done", dn, 0);
    sd_q.delete(); sl_q.delete(); ed_q.delete(); es_q.delete();
    sd_q.push_back(96'h77); sl_q.push_back(1'b1);
    ed_q.push_back(288'h77); es_q.push_back(36'h0_0000_0FFF);
    run_tile(1, 0);

    // Randomized tiles against the reference model
    for (int r = 0; r < 8; r++) begin
      int tot;
      tot = $urandom_range(1, 4);
      gen_random_tile(tot);
      run_tile(tot, 1);
    end

    // Asynchronous reset while a beat is waiting
    start_i = 1'b1; tot_beats_i = CNT_W'(1);
    @(posedge clk); #1;
    start_i = 1'b0;
    in_valid_i = 1'b1; in_data_i = 96'h5; in_last_i = 1'b1; z_ready_i = 1'b0;
    for (int cyc = 0; cyc < 50 && !z_valid_o; cyc++) begin
      @(posedge clk); #1;
    end
    chk_i("emit_before_reset", int'(z_valid_o), 1);
    in_valid_i = 1'b0; in_last_i = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk_idle_outputs("async_reset");
    @(posedge clk); #1;
    rst = 1'b0;

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/redmule_z_collector.md
Name: redmule_z_collector

Overview:
- Sits directly upstream of the streamer's Z sink, between the engine output and the `z_stream_i` port.
- Accepts narrow engine result slices (IN_W bits) over a valid/ready handshake.
- Packs PACK = DW/IN_W consecutive slices into one DW-wide beat with a per-byte strobe.
- Counts emitted beats against a programmed tile length and pulses `done_o` when the tile is fully drained.

Parameters:
- DW, 288: output beat width in bits; matches the streamer data width.
- IN_W, 96: engine slice width in bits. DW mod IN_W == 0 and IN_W mod 8 == 0 are enforced by elaboration assertions.
- CNT_W, 16: width of the beat counter and of `tot_beats_i`.

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset, asynchronous, active-high
- clear_i  in  1  synchronous soft clear
- start_i  in  1  tile start pulse; sampled only in IDLE
- tot_beats_i  in  CNT_W  output beats in the tile; sampled on start_i
- in_data_i  in  IN_W  engine result slice
- in_valid_i  in  1  slice valid
- in_last_i  in  1  slice is the last of its row; forces a partial beat
- in_ready_o  out  1  collector accepts a slice
- z_data_o  out  DW  packed beat to the Z sink
- z_strb_o  out  DW/8  byte strobes of the beat
- z_valid_o  out  1  beat valid
- z_ready_i  in  1  sink accepts the beat
- busy_o  out  1  high in every state except IDLE
- done_o  out  1  one-cycle pulse when the tile completes
- beat_cnt_o  out  CNT_W  beats emitted in the current tile
- stall_cnt_o  out  32  output backpressure cycles (see Optional Feature)

Behaviour:
- Reset: state IDLE; slot index 0; data register 0; strobe register 0; beat_cnt 0; tot register 0. Outputs `in_ready_o`, `z_valid_o`, `busy_o`, `done_o` are 0; `z_data_o`, `z_strb_o`, `beat_cnt_o`, `stall_cnt_o` are 0.
- `clear_i` has the same effect as reset, one cycle later (synchronous) and with priority over all other events. A clear arriving mid-tile drops any partial beat and produces no `done_o`.
- IDLE:
  - start_i with tot_beats_i == 0: `done_o` pulses the next cycle; state stays IDLE.
  - start_i with tot_beats_i != 0: latch tot, zero beat_cnt, go to ACC.
  - in_valid_i is ignored in IDLE.
- ACC: `in_ready_o` = 1. On each accepted slice:
  - Write it into slot `idx`, i.e. bits [idx*IN_W +: IN_W].
  - Set the strobes of that slot to all ones.
  - If idx == PACK-1 or in_last_i: go to EMIT and reset idx to 0. Otherwise idx increments.
  - Unfilled slots keep data 0 and strobe 0.
- EMIT: `z_valid_o` = 1 and `in_ready_o` = 0. Data and strobe stay stable until `z_ready_i`.
  - On handshake: beat_cnt increments, and the data and strobe registers are cleared.
  - If the new beat_cnt == tot: go to DONE, else go back to ACC.
- DONE: `done_o` = 1 for exactly one cycle, then go to IDLE. beat_cnt holds its final value until the next start.
- Latency: the last slice of a full beat is accepted at cycle t; `z_valid_o` is high at t+1. Throughput is one beat per PACK+1 cycles when there is no backpressure.
- Valid/ready rule: `z_valid_o` never deasserts without a handshake. `z_valid_o` does not depend combinationally on `z_ready_i`.
- The beat counter wraps are never reached, because tot ≤ 2^CNT_W − 1.
- A start_i pulse while busy is ignored.

Optional Feature:
- Macro `REDMULE_ZCOLL_STALL_CNT_EN`.
- When defined: a 32-bit saturating counter increments on every cycle with z_valid_o && !z_ready_i. It is zeroed on reset, clear_i, and accepted start_i, and is driven on `stall_cnt_o`.
- When undefined: no counter flops exist and `stall_cnt_o` is tied to 0.

Decomposition:
- In redmule_pkg:
  - enum `zcoll_state_e` with values IDLE, ACC, EMIT, DONE.
  - Constants `ZCOLL_IN_W` = 96.
  - `ZCOLL_PACK` = DW/IN_W.
- One sub-module, redmule_z_packer: the slot-indexed data/strobe register with write, clear and full/last detection.
- The FSM, beat counter and stall counter stay in the top module.

Test Plan:
- Full tile: tot = 2, six slices 0x1..0x6, no last, z_ready_i = 1.
  - Expect two beats, each with z_strb_o = all ones (36 bytes).
  - Beat 0 = {0x3, 0x2, 0x1}, beat 1 = {0x6, 0x5, 0x4}.
  - beat_cnt_o = 2, a single done_o pulse, busy_o = 0 afterwards.
- Partial beat: tot = 1, slice 0xA with in_last_i = 1 at slot 0.
  - Expect one beat with data[95:0] = 0xA and the upper bits 0.
  - z_strb_o = 0x0_0000_0FFF (low 12 bytes set).
- Backpressure: hold z_ready_i = 0 for 5 cycles during EMIT.
  - z_valid_o and z_data_o stay stable, in_ready_o = 0.
  - With the macro defined, stall_cnt_o = 5.
- Zero tile: start_i with tot = 0 → done_o pulses once the next cycle, z_valid_o never rises.
- Mid-tile abort: tot = 3, assert clear_i after 4 slices.
  - IDLE the next cycle, beat_cnt_o = 0, no done_o.
  - A following tile with tot = 1 packs correctly from slot 0.
- Reset: assert rst_i asynchronously during EMIT → all outputs are 0 immediately, with no clock edge required.
